// File: rtl/dbg_stream_pkg.sv
// Shared types and helpers for the framed debug telemetry UART streamer.
package dbg_stream_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } stream_state_e;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Sync byte + sequence byte + payload + checksum byte
    function automatic int frame_len(input int num_ch, input int data_w);
        return 3 + num_ch * (data_w / 8);
    endfunction

    function automatic logic [7:0] chk_accum(input logic [7:0] chk, input logic [7:0] b);
        return chk ^ b;
    endfunction

endpackage

// File: rtl/dbg_tick_gen.sv
// Snapshot period timer: counts 0..PERIOD-1 while enabled, tick on the last count.
module dbg_tick_gen
#(
    parameter int PERIOD = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);
    localparam int               CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] timer_r;

    // Period counter, held at zero while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= '0;
        end else if (!enable) begin
            timer_r <= '0;
        end else if (timer_r == LAST) begin
            timer_r <= '0;
        end else begin
            timer_r <= timer_r + CNT_W'(1);
        end
    end

    assign tick = enable && (timer_r == LAST);

endmodule

// File: rtl/dbg_uart_streamer.sv
// Periodic / on-demand framed debug telemetry streamer feeding a byte-wide UART transmitter.
module dbg_uart_streamer
    import dbg_stream_pkg::*;
#(
    parameter int         NUM_CH    = 2,
    parameter int         DATA_W    = 32,
    parameter int         PERIOD    = 10000,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    parameter int         ACK_TO    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     trigger,
    input  logic [NUM_CH*DATA_W-1:0] dbg_data,
    input  logic                     uart_tx_busy,
    output logic                     uart_tx_en,
    output logic [7:0]               uart_tx_data,
    output logic                     frame_active,
    output logic [7:0]               overrun_cnt,
    output logic                     ack_err
);
    localparam int               FRAME_LEN = frame_len(NUM_CH, DATA_W);
    localparam int               IDX_W     = $clog2(FRAME_LEN);
    localparam int               ACK_W     = $clog2(ACK_TO + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_TO - 1);

    stream_state_e             state_r;
    stream_state_e             state_nxt_s;
    logic                      tick_s;
    logic                      req_s;
    logic                      capture_s;
    logic                      issue_s;
    logic                      next_byte_s;
    logic                      done_s;
    logic                      abort_s;
    logic                      last_s;
    logic                      data_byte_s;
    logic [7:0]                cur_byte_s;
    logic [IDX_W-1:0]          byte_idx_r;
    logic [NUM_CH*DATA_W-1:0]  snap_r;
    logic [7:0]                chk_r;
    logic [7:0]                seq_r;
    logic [ACK_W-1:0]          ack_cnt_r;

    dbg_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick_s)
    );

    assign req_s       = (tick_s || trigger) && enable;
    assign last_s      = (byte_idx_r == LAST_IDX);
    assign data_byte_s = (byte_idx_r >= IDX_W'(2)) && !last_s;

    // Snapshot is consumed by shifting, so the next payload byte is always in the low lane
    always_comb begin
        cur_byte_s = snap_r[7:0];
        if (byte_idx_r == IDX_W'(0)) begin
            cur_byte_s = SYNC_BYTE;
        end else if (byte_idx_r == IDX_W'(1)) begin
            cur_byte_s = seq_r;
        end else if (last_s) begin
            cur_byte_s = chk_r;
        end else begin
            cur_byte_s = snap_r[7:0];
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        issue_s     = 1'b0;
        next_byte_s = 1'b0;
        done_s      = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = SEND;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (!uart_tx_busy) begin
                    issue_s     = 1'b1;
                    state_nxt_s = WAIT_ACK;
                end else begin
                    state_nxt_s = SEND;
                end
            end
            WAIT_ACK: begin
                if (uart_tx_busy) begin
                    state_nxt_s = WAIT_DONE;
                end else if (ack_cnt_r == ACK_LAST) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_ACK;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    if (last_s) begin
                        done_s      = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        next_byte_s = 1'b1;
                        state_nxt_s = SEND;
                    end
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= 8'h00;
            frame_active <= 1'b0;
            overrun_cnt  <= 8'h00;
            ack_err      <= 1'b0;
            seq_r        <= 8'h00;
            chk_r        <= 8'h00;
            byte_idx_r   <= '0;
            snap_r       <= '0;
            ack_cnt_r    <= '0;
        end else begin
            state_r    <= state_nxt_s;
            uart_tx_en <= issue_s;
            ack_cnt_r  <= (state_r == WAIT_ACK) ? ack_cnt_r + ACK_W'(1) : '0;
            if (capture_s) begin
                snap_r       <= dbg_data;
                byte_idx_r   <= '0;
                chk_r        <= 8'h00;
                frame_active <= 1'b1;
            end
            if (issue_s) begin
                uart_tx_data <= cur_byte_s;
                if ((byte_idx_r != IDX_W'(0)) && !last_s) begin
                    chk_r <= chk_accum(chk_r, cur_byte_s);
                end
                if (data_byte_s) begin
                    snap_r <= snap_r >> 8;
                end
            end
            if (next_byte_s) begin
                byte_idx_r <= byte_idx_r + IDX_W'(1);
            end
            if (done_s) begin
                frame_active <= 1'b0;
                seq_r        <= seq_r + 8'd1;
            end
            if (abort_s) begin
                frame_active <= 1'b0;
                ack_err      <= 1'b1;
            end
            // Requests landing outside IDLE (including the return-to-IDLE cycle) are dropped
            if (req_s && (state_r != IDLE) && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dbg_uart_streamer.sv
// Scoreboard bench for dbg_uart_streamer with a small uart_tx responder model.
module tb_dbg_uart_streamer;

    localparam logic [63:0] D1 = {32'hDEADBEEF, 32'h11223344};
    localparam logic [63:0] D2 = {32'h0BADF00D, 32'hCAFEBABE};

    typedef struct packed {
        logic [7:0] b;
        logic       first;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        trigger;
    logic [63:0] dbg_data;
    logic        uart_tx_busy;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        frame_active;
    logic [7:0]  overrun_cnt;
    logic        ack_err;

    exp_t        exp_q[$];
    int unsigned sof_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int          en_cnt = 0;
    int          busy_len = 3;
    int          busy_left = 0;
    bit          pending = 1'b0;
    bit          silent = 1'b0;
    bit          force_busy = 1'b0;

    logic [7:0] frame_s0 [11] = '{8'hA5, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h66};
    logic [7:0] frame_s1 [11] = '{8'hA5, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11,
                                  8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h67};

    dbg_uart_streamer #(
        .NUM_CH    (2),
        .DATA_W    (32),
        .PERIOD    (100),
        .SYNC_BYTE (8'hA5),
        .ACK_TO    (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .trigger      (trigger),
        .dbg_data     (dbg_data),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .frame_active (frame_active),
        .overrun_cnt  (overrun_cnt),
        .ack_err      (ack_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_list(input logic [7:0] arr [11]);
        for (int i = 0; i < 11; i++) exp_q.push_back('{b: arr[i], first: (i == 0)});
    endtask

    // Reference frame model: sync, seq, payload LSB first, XOR of everything after sync
    task automatic push_frame(input logic [7:0] seq, input logic [63:0] d, input int nbytes);
        logic [7:0] bytes [11];
        logic [7:0] chk;
        bytes[0] = 8'hA5;
        bytes[1] = seq;
        chk = seq;
        for (int i = 0; i < 8; i++) begin
            bytes[2+i] = d[8*i +: 8];
            chk = chk ^ d[8*i +: 8];
        end
        bytes[10] = chk;
        for (int i = 0; i < nbytes; i++) exp_q.push_back('{b: bytes[i], first: (i == 0)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_active && (k < budget));
        check({name, "_done"}, 32'(frame_active), 32'd0);
        check({name, "_all_bytes"}, 32'(exp_q.size()), 32'd0);
    endtask

    // uart_tx responder: busy rises one cycle after en and stays high busy_len cycles
    initial begin : uart_model
        uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_left > 0) busy_left--;
            if (pending) begin
                pending   = 1'b0;
                busy_left = busy_len;
            end
            if (uart_tx_en && !silent) pending = 1'b1;
            uart_tx_busy = force_busy || (busy_left > 0);
        end
    end

    initial begin : monitor
        bit   prev_en;
        exp_t e;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_tx_en) begin
                en_cnt++;
                check("en_gap", 32'(prev_en), 32'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_unexpected: got %0h expected none", uart_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(uart_tx_data), 32'(e.b));
                    if (e.first) sof_q.push_back(cyc);
                end
            end
            prev_en = uart_tx_en;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          k;
        int          s0;
        int          e0;
        int unsigned t0;
        int unsigned t_en;
        rst = 1'b1; enable = 1'b0; trigger = 1'b0; dbg_data = D1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_en", 32'(uart_tx_en), 32'd0);
        check("rst_data", 32'(uart_tx_data), 32'd0);
        check("rst_active", 32'(frame_active), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        step(); rst = 1'b0;

        // Basic triggered frames, seq 00 then 01
        push_list(frame_s0);
        step(); enable = 1'b1; trigger = 1'b1; t0 = cyc;
        step(); trigger = 1'b0;
        check("basic_active_rise", 32'(frame_active), 32'd1);
        wait_idle("basic0", 200);
        check("basic_latency", 32'((sof_q.size() == 1) && (sof_q[0] - t0 >= 2)), 32'd1);
        step(); enable = 1'b0;
        push_list(frame_s1);
        step(); enable = 1'b1; trigger = 1'b1;
        step(); trigger = 1'b0;
        wait_idle("basic1", 200);
        step(); enable = 1'b0;

        // Periodic frames every 100 cycles, no overruns
        push_frame(8'h02, D1, 11);
        push_frame(8'h03, D1, 11);
        push_frame(8'h04, D1, 11);
        s0 = sof_q.size();
        step(); enable = 1'b1;
        repeat (320) @(posedge clk);
        #1 enable = 1'b0;
        wait_idle("periodic", 200);
        check("periodic_frames", 32'(sof_q.size() - s0), 32'd3);
        if (sof_q.size() - s0 == 3) begin
            check("period_gap1", sof_q[s0+1] - sof_q[s0], 32'd100);
            check("period_gap2", sof_q[s0+2] - sof_q[s0+1], 32'd100);
        end
        check("periodic_overrun", 32'(overrun_cnt), 32'd0);

        // Slow UART: two ticks dropped during one long frame
        busy_len = 20;
        push_frame(8'h05, D1, 11);
        step(); enable = 1'b1; trigger = 1'b1;
        step(); trigger = 1'b0;
        repeat (279) @(posedge clk);
        #1 enable = 1'b0;
        wait_idle("ovr_ticks", 400);
        check("ovr_ticks_cnt", 32'(overrun_cnt), 32'd2);

        // Busy held before SEND, data changed after snapshot, overrun saturation
        busy_len = 3;
        step(); force_busy = 1'b1;
        step(); step();
        push_frame(8'h06, D1, 11);
        e0 = en_cnt;
        enable = 1'b1; trigger = 1'b1;
        step(); dbg_data = D2;
        repeat (9) step();
        @(negedge clk);
        check("ovr_partial", 32'(overrun_cnt), 32'd11);
        repeat (290) step();
        trigger = 1'b0; enable = 1'b0;
        @(negedge clk);
        check("ovr_saturated", 32'(overrun_cnt), 32'd255);
        check("busy_gating", 32'(en_cnt - e0), 32'd0);
        step(); force_busy = 1'b0;
        wait_idle("snapshot", 200);
        check("ovr_hold", 32'(overrun_cnt), 32'd255);

        // Ack timeout: busy never rises
        step(); dbg_data = D1; silent = 1'b1;
        exp_q.push_back('{b: 8'hA5, first: 1'b1});
        e0 = en_cnt;
        enable = 1'b1; trigger = 1'b1;
        step(); trigger = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!uart_tx_en && (k < 20));
        t_en = cyc;
        check("ack_en_seen", 32'(uart_tx_en), 32'd1);
        k = 0;
        do begin @(negedge clk); k++; end while (!ack_err && (k < 40));
        check("ack_err_set", 32'(ack_err), 32'd1);
        check("ack_to_cycles", cyc - t_en, 32'd16);
        check("ack_abort_active", 32'(frame_active), 32'd0);
        repeat (5) @(negedge clk);
        check("ack_single_en", 32'(en_cnt - e0), 32'd1);
        step(); enable = 1'b0; silent = 1'b0;

        // Reset during byte 4 of a frame still carrying seq 07
        push_frame(8'h07, D1, 4);
        e0 = en_cnt;
        step(); enable = 1'b1; trigger = 1'b1;
        step(); trigger = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while ((en_cnt - e0 < 4) && (k < 100));
        check("ack_err_sticky", 32'(ack_err), 32'd1);
        step(); rst = 1'b1; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_en", 32'(uart_tx_en), 32'd0);
        check("midrst_active", 32'(frame_active), 32'd0);
        check("midrst_overrun", 32'(overrun_cnt), 32'd0);
        check("midrst_ack_err", 32'(ack_err), 32'd0);
        check("midrst_bytes", 32'(exp_q.size()), 32'd0);
        step(); rst = 1'b0; busy_left = 0; pending = 1'b0;
        push_list(frame_s0);
        step(); enable = 1'b1; trigger = 1'b1;
        step(); trigger = 1'b0;
        wait_idle("post_rst", 200);
        step(); enable = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dbg_uart_streamer.md
Name: dbg_uart_streamer

Overview:
Periodic, framed debug-telemetry streamer. It generalises the single-register UART dump at the core top level to NUM_CH debug words of DATA_W bits each, with sync byte, sequence number, checksum, on-demand trigger and overrun accounting. It sits between the core's debug taps (x-register and other debug buses) and uart_tx, driving uart_tx_en/uart_tx_data and observing uart_tx_busy.

Parameters:
NUM_CH, 2, number of debug words per frame (1..16)
DATA_W, 32, width of each debug word; must be a multiple of 8
PERIOD, 10000, clk cycles between automatic snapshots (>=2)
SYNC_BYTE, 8'hA5, frame start marker
ACK_TO, 16, max cycles to wait for uart_tx_busy to rise after a tx_en pulse

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  when low, the period timer is held at 0 and no new frames start; a frame in flight completes
trigger  in  1  single-cycle request for an immediate snapshot
dbg_data  in  NUM_CH*DATA_W  flattened debug words; channel k is bits [k*DATA_W +: DATA_W]
uart_tx_busy  in  1  from uart_tx
uart_tx_en  out  1  one-cycle send strobe to uart_tx
uart_tx_data  out  8  byte to send; valid while uart_tx_en is high
frame_active  out  1  high from snapshot until the last byte completes
overrun_cnt  out  8  saturating count of snapshot requests dropped while busy
ack_err  out  1  sticky; set on ACK_TO timeout; cleared only by rst

Behaviour:
- Reset: uart_tx_en=0, uart_tx_data=0, frame_active=0, overrun_cnt=0, ack_err=0, seq=0, timer=0, state=IDLE. Reset mid-frame aborts the frame; uart_tx_en is 0 after the reset edge.
- Timer: counts 0..PERIOD-1 while enable=1, then wraps. tick=1 in the cycle it equals PERIOD-1. When enable=0, timer=0.
- Request: req = (tick | trigger) & enable. A simultaneous tick and trigger counts as one request.
- Frame: SYNC_BYTE, seq, then for channels 0..NUM_CH-1 the DATA_W/8 bytes of each word, LSB first, then CHK. CHK = XOR of all bytes after SYNC. Length = 3 + NUM_CH*DATA_W/8.
- seq increments mod 256 after each completed frame. Aborted frames do not increment seq.
- State machine:
  - IDLE: on req, capture all of dbg_data into the snapshot buffer, set byte_idx=0, set frame_active=1, go to SEND.
  - SEND: if uart_tx_busy=0, drive uart_tx_en=1 for exactly one cycle with uart_tx_data=byte[byte_idx], then go to WAIT_ACK. If uart_tx_busy=1, stay in SEND.
  - WAIT_ACK: when uart_tx_busy=1, go to WAIT_DONE. After ACK_TO cycles with busy low, set ack_err, clear frame_active, go to IDLE (frame aborted).
  - WAIT_DONE: when uart_tx_busy=0, the byte is complete. If it was the last byte, clear frame_active, increment seq, go to IDLE. Otherwise increment byte_idx and go to SEND.
- uart_tx_en is never high in two consecutive cycles.
- Latency: req at cycle t gives uart_tx_en=1 no earlier than t+2.
- Data captured at the snapshot cycle is transmitted unchanged even if dbg_data changes mid-frame.
- CHK is accumulated as bytes are issued; it is not recomputed at the end of the frame.
- Overrun: a req while state!=IDLE increments overrun_cnt, saturating at 255. A req arriving on the same cycle the FSM returns to IDLE is dropped and counted.
- Deasserting enable mid-frame does not stop the frame in flight.

Decomposition:
- Package dbg_stream_pkg holds:
  - the FSM state enum (IDLE, SEND, WAIT_ACK, WAIT_DONE);
  - the default SYNC constant;
  - a function for frame length from NUM_CH and DATA_W.
- One sub-module, dbg_tick_gen, holds the PERIOD counter with enable and the tick output.

Test Plan:
- Basic frame: NUM_CH=2, DATA_W=32, dbg_data={32'hDEADBEEF,32'h11223344}, trigger pulse, bench uart_tx model (busy one cycle after en, for 20 cycles) -> bytes A5 00 44 33 22 11 EF BE AD DE 66; frame_active then falls; a second frame carries seq=01.
- Periodic: PERIOD=100, enable held high, no trigger -> frame starts after each tick every 100 cycles; overrun_cnt=0 when the frame is shorter than the period.
- Overrun: PERIOD=20, busy 20 cycles per byte -> overrun_cnt increments once per dropped tick and saturates at 255; frames keep their integrity.
- Ack timeout: tie uart_tx_busy=0 -> one uart_tx_en pulse, ack_err=1 after 16 cycles, state IDLE, seq unchanged.
- Reset mid-frame: assert rst during byte 4 -> next cycle uart_tx_en=0, frame_active=0, overrun_cnt=0; the next frame starts with A5 00.
- Snapshot stability and busy gating: change dbg_data after the snapshot cycle -> original values are transmitted; hold busy=1 before SEND -> no uart_tx_en until busy falls.
